// File: rtl/scene_pkg.sv
// Shared constants, state encodings and colour lookup for the scene sequencer.
// Contents: scene ids, fixed scene colours, sequencer FSM states, H_ACTIVE,
// and scene_colour() which maps a scene id to its background colour.
package scene_pkg;

  localparam int unsigned SCENE_W  = 2;
  localparam int unsigned COLOUR_W = 6;
  localparam int unsigned X_W      = 10;
  localparam int unsigned FRAME_W  = 10;
  localparam int unsigned WPOS_W   = 11;
  localparam int unsigned H_ACTIVE = 640;

  localparam logic [SCENE_W-1:0] SCENE_GRASS = 2'd0;
  localparam logic [SCENE_W-1:0] SCENE_UW    = 2'd1;
  localparam logic [SCENE_W-1:0] SCENE_BLUE  = 2'd2;
  localparam logic [SCENE_W-1:0] SCENE_GREEN = 2'd3;

  localparam logic [COLOUR_W-1:0] BLUE_RGB  = 6'b00_01_11;
  localparam logic [COLOUR_W-1:0] GREEN_RGB = 6'b00_11_01;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_WIPE = 1'b1
  } seq_state_e;

  // Background colour for a scene id; animated scenes come from outside.
  function automatic logic [COLOUR_W-1:0] scene_colour(
    input logic [SCENE_W-1:0]  s,
    input logic [COLOUR_W-1:0] bg0,
    input logic [COLOUR_W-1:0] bg1
  );
    logic [COLOUR_W-1:0] c;
    case (s)
      SCENE_GRASS: c = bg0;
      SCENE_UW:    c = bg1;
      SCENE_BLUE:  c = BLUE_RGB;
      default:     c = GREEN_RGB;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: rising-edge detect on vsync plus a free-running
// frame counter. Shared with the sound block.
// Ports: clk, reset (async, active-high), vsync in;
//        tick_c (combinational, one clk wide), frame_count (registered) out.
module frame_tick_gen
  import scene_pkg::*;
#(
  parameter int unsigned COUNT_W = FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  output logic               tick_c,
  output logic [COUNT_W-1:0] frame_count
);

  logic vsync_q;

  assign tick_c = vsync & ~vsync_q;

  // Edge-detect history and frame counter (wraps naturally).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      frame_count <= '0;
    end else begin
      vsync_q <= vsync;
      if (tick_c) frame_count <= frame_count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Per-pixel scene compositor and frame-level scene scheduler.
// Picks one of four backgrounds, overlays the goose sprite, registers the
// 6-bit colour, and sequences scene changes (manual via sel, or automatic
// every HOLD_FRAMES frames).
// Optional feature macro SCENE_SEQ_WIPE_EN: when defined, transitions are a
// left-to-right wipe advancing WIPE_STEP pixels per frame; when undefined,
// transitions are hard cuts and wiping is tied low.
// Ports: clk, reset (async, active-high), vsync, video_active, pix_x,
//        auto_mode, sel (async), in_goose, goose_rgb, bg0_rgb, bg1_rgb in;
//        rgb, frame_count, scene, wiping out.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 240,
  parameter int unsigned WIPE_STEP   = 32,
  parameter int unsigned H_ACTIVE    = scene_pkg::H_ACTIVE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vsync,
  input  logic                video_active,
  input  logic [X_W-1:0]      pix_x,
  input  logic                auto_mode,
  input  logic [SCENE_W-1:0]  sel,
  input  logic                in_goose,
  input  logic [COLOUR_W-1:0] goose_rgb,
  input  logic [COLOUR_W-1:0] bg0_rgb,
  input  logic [COLOUR_W-1:0] bg1_rgb,
  output logic [COLOUR_W-1:0] rgb,
  output logic [FRAME_W-1:0]  frame_count,
  output logic [SCENE_W-1:0]  scene,
  output logic                wiping
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  if (HOLD_FRAMES == 0 || WIPE_STEP == 0) begin : g_param_check
    $error("scene_sequencer: HOLD_FRAMES and WIPE_STEP must be non-zero");
  end

  logic                tick_c;
  logic [SCENE_W-1:0]  sel_meta, sel_sync;
  logic [SCENE_W-1:0]  scene_nxt, base_scene_c;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                hold_expired_c, manual_req_c;
  logic [COLOUR_W-1:0] rgb_nxt_c;

  frame_tick_gen #(.COUNT_W(FRAME_W)) u_frame_tick (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .tick_c      (tick_c),
    .frame_count (frame_count)
  );

  // Two-flop synchroniser for the asynchronous select pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_meta <= '0;
      sel_sync <= '0;
    end else begin
      sel_meta <= sel;
      sel_sync <= sel_meta;
    end
  end

  assign hold_expired_c = auto_mode && (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));

`ifdef SCENE_SEQ_WIPE_EN
  seq_state_e          state, state_nxt;
  logic [SCENE_W-1:0]  sel_prev, pend_sel, pend_sel_nxt, req_scene_c;
  logic [SCENE_W-1:0]  next_scene, next_scene_nxt;
  logic                pend_vld, pend_vld_nxt;
  logic [WPOS_W-1:0]   wipe_pos, wipe_pos_nxt, wipe_sum_c;
  logic                wipe_done_c;

  // A select change seen during a wipe is remembered until the next HOLD tick.
  assign req_scene_c  = pend_vld ? pend_sel : sel_sync;
  assign manual_req_c = !auto_mode && (req_scene_c != scene);
  assign wipe_sum_c   = wipe_pos + WPOS_W'(WIPE_STEP);
  assign wipe_done_c  = wipe_sum_c >= WPOS_W'(H_ACTIVE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nxt;
  end

  // Next-state logic; manual and auto triggers both start a wipe.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: if (tick_c && (manual_req_c || hold_expired_c)) state_nxt = ST_WIPE;
      ST_WIPE: if (tick_c && wipe_done_c) state_nxt = ST_HOLD;
      default: state_nxt = ST_HOLD;
    endcase
  end

  // Datapath updates; manual request takes priority over auto expiry.
  always_comb begin
    scene_nxt      = scene;
    next_scene_nxt = next_scene;
    hold_nxt       = hold_cnt;
    wipe_pos_nxt   = wipe_pos;
    pend_sel_nxt   = pend_sel;
    pend_vld_nxt   = pend_vld;
    if (!auto_mode) hold_nxt = '0;
    if (sel_sync != sel_prev) begin
      pend_sel_nxt = sel_sync;
      pend_vld_nxt = 1'b1;
    end
    case (state)
      ST_HOLD: begin
        if (tick_c) begin
          pend_vld_nxt = 1'b0;
          if (manual_req_c) begin
            next_scene_nxt = req_scene_c;
            wipe_pos_nxt   = '0;
            hold_nxt       = '0;
          end else if (hold_expired_c) begin
            next_scene_nxt = scene + SCENE_W'(1);
            wipe_pos_nxt   = '0;
            hold_nxt       = '0;
          end else if (auto_mode) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_WIPE: begin
        if (tick_c) begin
          if (wipe_done_c) begin
            scene_nxt    = next_scene;
            wipe_pos_nxt = '0;
            hold_nxt     = '0;
          end else begin
            wipe_pos_nxt = wipe_sum_c;
          end
        end
      end
      default: ;
    endcase
  end

  // Wipe-only registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_prev   <= '0;
      pend_sel   <= '0;
      pend_vld   <= 1'b0;
      next_scene <= SCENE_GRASS;
      wipe_pos   <= '0;
      wiping     <= 1'b0;
    end else begin
      sel_prev   <= sel_sync;
      pend_sel   <= pend_sel_nxt;
      pend_vld   <= pend_vld_nxt;
      next_scene <= next_scene_nxt;
      wipe_pos   <= wipe_pos_nxt;
      wiping     <= (state_nxt == ST_WIPE);
    end
  end

  // Columns left of the wipe boundary already show the incoming scene.
  assign base_scene_c = (wiping && (WPOS_W'(pix_x) < wipe_pos)) ? next_scene : scene;
`else
  assign manual_req_c = !auto_mode && (sel_sync != scene);

  // Hard-cut sequencing: the scene switches on the triggering tick.
  always_comb begin
    scene_nxt = scene;
    hold_nxt  = hold_cnt;
    if (!auto_mode) hold_nxt = '0;
    if (tick_c) begin
      if (manual_req_c) begin
        scene_nxt = sel_sync;
        hold_nxt  = '0;
      end else if (hold_expired_c) begin
        scene_nxt = scene + SCENE_W'(1);
        hold_nxt  = '0;
      end else if (auto_mode) begin
        hold_nxt = hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign wiping       = 1'b0;
  assign base_scene_c = scene;
`endif

  // Pixel colour: blanking, then sprite, then background.
  always_comb begin
    rgb_nxt_c = '0;
    if (video_active && (pix_x < X_W'(H_ACTIVE))) begin
      rgb_nxt_c = in_goose ? goose_rgb : scene_colour(base_scene_c, bg0_rgb, bg1_rgb);
    end
  end

  // Shared registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb      <= '0;
      scene    <= SCENE_GRASS;
      hold_cnt <= '0;
    end else begin
      rgb      <= rgb_nxt_c;
      scene    <= scene_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer. A frame-level reference model
// tracks scene, wipe progress (ticks into the wipe) and hold count.
module tb_scene_sequencer;

  localparam int unsigned HOLD = 3;
  localparam int unsigned STEP = 32;
  localparam int unsigned HACT = 640;

  logic       clk = 1'b0;
  logic       reset, vsync, video_active, auto_mode, in_goose;
  logic [9:0] pix_x;
  logic [1:0] sel;
  logic [5:0] goose_rgb, bg0_rgb, bg1_rgb;
  logic [5:0] rgb;
  logic [9:0] frame_count;
  logic [1:0] scene;
  logic       wiping;

  always #5 clk = ~clk;

  scene_sequencer #(.HOLD_FRAMES(HOLD), .WIPE_STEP(STEP), .H_ACTIVE(HACT)) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .video_active (video_active),
    .pix_x        (pix_x),
    .auto_mode    (auto_mode),
    .sel          (sel),
    .in_goose     (in_goose),
    .goose_rgb    (goose_rgb),
    .bg0_rgb      (bg0_rgb),
    .bg1_rgb      (bg1_rgb),
    .rgb          (rgb),
    .frame_count  (frame_count),
    .scene        (scene),
    .wiping       (wiping)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int m_frames, m_scene, m_next, m_hold, m_wt;
  bit m_wiping;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_frames = 0; m_scene = 0; m_next = 0; m_hold = 0; m_wt = 0; m_wiping = 0;
  endtask

  task automatic model_start(input int t);
`ifdef SCENE_SEQ_WIPE_EN
    m_next = t; m_wiping = 1; m_wt = 0;
`else
    m_scene = t;
`endif
    m_hold = 0;
  endtask

  // One frame tick of the scheduling rules.
  task automatic model_tick();
    m_frames = (m_frames + 1) % 1024;
    if (m_wiping) begin
      m_wt++;
      if (m_wt * STEP >= HACT) begin
        m_scene = m_next; m_wiping = 0; m_wt = 0; m_hold = 0;
      end
    end else if (!auto_mode && int'(sel) != m_scene) begin
      model_start(int'(sel));
    end else if (auto_mode) begin
      if (m_hold == HOLD - 1) model_start((m_scene + 1) % 4);
      else m_hold++;
    end else begin
      m_hold = 0;
    end
  endtask

  function automatic logic [5:0] colour_of(input int s);
    case (s)
      0: return bg0_rgb;
      1: return bg1_rgb;
      2: return 6'b000111;
      default: return 6'b001101;
    endcase
  endfunction

  function automatic logic [5:0] exp_pix();
    int s;
    if (!video_active || int'(pix_x) >= HACT) return 6'd0;
    if (in_goose) return goose_rgb;
    s = (m_wiping && int'(pix_x) < m_wt * STEP) ? m_next : m_scene;
    return colour_of(s);
  endfunction

  task automatic frame();
    vsync = 1'b1;
    @(posedge clk); #1;
    model_tick();
    step(1);
    vsync = 1'b0;
    step(4);
    chk("frame_count", 16'(frame_count), 16'(m_frames));
    chk("scene", 16'(scene), 16'(m_scene));
    chk("wiping", 16'(wiping), 16'(m_wiping));
  endtask

  task automatic set_sel(input logic [1:0] v);
    sel = v;
    step(4);
  endtask

  task automatic set_auto(input logic v);
    auto_mode = v;
    if (!v) m_hold = 0;
    step(2);
  endtask

  task automatic finish_wipe();
    for (int i = 0; i < 30 && (m_wiping || wiping); i++) frame();
    chk("wipe_done", 16'(wiping), 16'd0);
  endtask

  task automatic pix(input string tag, input logic va, input logic [9:0] x, input logic g,
                     input logic [5:0] expected);
    video_active = va; pix_x = x; in_goose = g;
    step(1);
    chk(tag, 16'(rgb), 16'(expected));
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++) begin
      pix_x        = 10'($urandom_range(0, 799));
      video_active = ($urandom_range(0, 3) != 0) && (pix_x < 10'(HACT));
      in_goose     = ($urandom_range(0, 3) == 0);
      goose_rgb    = 6'($urandom);
      bg0_rgb      = 6'($urandom);
      bg1_rgb      = 6'($urandom);
      step(1);
      chk("rand_pix", 16'(rgb), 16'(exp_pix()));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gap, nchg;
    logic [1:0] prev_scene;
    logic prev_wiping;
    logic [1:0] seq[$];

    reset = 1'b1; vsync = 1'b0; video_active = 1'b1; pix_x = 10'd100;
    auto_mode = 1'b0; sel = 2'd0; in_goose = 1'b0;
    goose_rgb = 6'd0; bg0_rgb = 6'b100000; bg1_rgb = 6'b010100;
    model_reset();
    step(3);
    reset = 1'b0;
    step(2);
    frame();
    frame();

    // Reset asserted mid-frame while vsync is high.
    vsync = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    chk("rst_rgb", 16'(rgb), 16'd0);
    chk("rst_scene", 16'(scene), 16'd0);
    chk("rst_fc", 16'(frame_count), 16'd0);
    chk("rst_wiping", 16'(wiping), 16'd0);
    vsync = 1'b0;
    step(1);
    reset = 1'b0;
    model_reset();
    step(2);
    chk("post_rst_rgb", 16'(rgb), 16'(exp_pix()));
    frame();
    chk("first_tick_fc", 16'(frame_count), 16'd1);

    // Auto mode: scenes 0,1,2,3,0, each transition starts on the 3rd hold tick.
    set_auto(1'b1);
    gap = 0; nchg = 0; prev_scene = scene; prev_wiping = wiping;
    for (int i = 0; i < 200 && nchg < 4; i++) begin
      frame();
      gap++;
      if (wiping && !prev_wiping) chk("auto_gap", 16'(gap), 16'(HOLD));
      if (scene != prev_scene) begin
`ifndef SCENE_SEQ_WIPE_EN
        chk("auto_gap", 16'(gap), 16'(HOLD));
`endif
        seq.push_back(scene);
        nchg++;
        gap = 0;
      end
      prev_scene = scene; prev_wiping = wiping;
    end
    chk("auto_changes", 16'(nchg), 16'd4);
    for (int k = 0; k < seq.size(); k++) chk("auto_seq", 16'(seq[k]), 16'((k + 1) % 4));
    set_auto(1'b0);

    // Manual 0 -> 2.
    set_sel(2'd2);
    frame();
`ifdef SCENE_SEQ_WIPE_EN
    chk("manual_wipe_start", 16'(wiping), 16'd1);
`endif
    finish_wipe();
    chk("manual_scene", 16'(scene), 16'd2);
    pix("blue_pix", 1'b1, 10'd100, 1'b0, 6'b000111);

    // Goose priority and blanking.
    goose_rgb = 6'b111111;
    pix("goose", 1'b1, 10'd200, 1'b1, 6'b111111);
    pix("blank", 1'b0, 10'd200, 1'b1, 6'd0);
    pix("blank_hblank", 1'b0, 10'd700, 1'b0, 6'd0);

    // Back to 0, then a 0 -> 3 wipe inspected after five ticks.
    set_sel(2'd0);
    frame();
    finish_wipe();
    set_sel(2'd3);
    for (int i = 0; i < 6; i++) frame();
`ifdef SCENE_SEQ_WIPE_EN
    pix("wipe_159", 1'b1, 10'd159, 1'b0, 6'b001101);
    pix("wipe_160", 1'b1, 10'd160, 1'b0, bg0_rgb);
`endif
    rand_pix(6);
    finish_wipe();
    chk("green_scene", 16'(scene), 16'd3);

    // Two select changes during a wipe: only the last one is followed.
    set_sel(2'd0);
    frame();
    frame();
    set_sel(2'd1);
    frame();
    set_sel(2'd3);
    finish_wipe();
    frame();
    finish_wipe();
    chk("pending_latest", 16'(scene), 16'd3);

    // Randomized sequencing with occasional auto toggles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) set_sel(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) set_auto(~auto_mode);
      frame();
      rand_pix(2);
    end

    // Reset in the middle of a transition.
    set_auto(1'b0);
    finish_wipe();
    set_sel(2'((m_scene + 1) % 4));
    frame();
    frame();
    reset = 1'b1;
    step(1);
    chk("rst_mid_scene", 16'(scene), 16'd0);
    chk("rst_mid_wiping", 16'(wiping), 16'd0);
    chk("rst_mid_fc", 16'(frame_count), 16'd0);
    chk("rst_mid_rgb", 16'(rgb), 16'd0);
    sel = 2'd0;
    step(2);
    reset = 1'b0;
    model_reset();
    step(3);
    frame();
    chk("rst_mid_first_fc", 16'(frame_count), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Per-pixel scene compositor and frame-level scheduler for the VGA top level.
- Selects one of four background scenes:
  - scene 0: moving grass
  - scene 1: UW bouncing
  - scene 2: solid blue
  - scene 3: solid green
- Overlays the goose sprite on top of the background.
- Registers the final 6-bit colour to drive the TinyVGA PMOD.
- Sequences scene changes, either manually from ui_in or automatically every HOLD_FRAMES frames, using a left-to-right wipe. Also owns the frame counter that animated backgrounds consume.

Parameters:
- HOLD_FRAMES, 240: frames a scene is held in auto mode before advancing.
- WIPE_STEP, 32: pixels the wipe boundary advances per frame.
- H_ACTIVE, 640: visible line width in pixels; the wipe completes at this width.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  vertical sync from hvsync_generator; its rising edge is the frame tick
- video_active  in  1  high inside the visible area
- pix_x  in  10  current pixel column
- auto_mode  in  1  1 = auto-cycle scenes, 0 = manual
- sel  in  2  manual scene select; asynchronous pin, synchronised inside the block
- in_goose  in  1  sprite coverage for the current pixel
- goose_rgb  in  6  sprite colour {R[1:0],G[1:0],B[1:0]}
- bg0_rgb  in  6  scene 0 colour
- bg1_rgb  in  6  scene 1 colour
- rgb  out  6  registered pixel colour {R,G,B}
- frame_count  out  10  frames since reset, wraps 1023 -> 0
- scene  out  2  currently displayed scene
- wiping  out  1  high while a transition is in progress

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, every register clears:
  - rgb=0, frame_count=0, scene=0, wiping=0
  - next_scene=0, hold_cnt=0, wipe_pos=0
  - pending flag=0, sync flops=0
- Frame tick:
  - vsync is sampled into a register; tick = vsync & ~vsync_q, one cycle wide.
  - frame_count increments on each tick.
- Select input: sel passes through a 2-flop synchroniser, followed by a change-detect register.
- Scene colours:
  - scene 0 = bg0_rgb
  - scene 1 = bg1_rgb
  - scene 2 = 6'b00_01_11
  - scene 3 = 6'b00_11_01
- Pixel path:
  - Base scene is next_scene if wiping and pix_x < wipe_pos, otherwise scene.
  - in_goose overrides with goose_rgb.
  - video_active=0 forces 0.
  - Result is registered into rgb, giving one clk of latency from the inputs.
- FSM state HOLD:
  - Manual request: if !auto_mode and the synchronised sel differs from scene, then at the next tick set next_scene=sel, wipe_pos=0, go to WIPE.
  - Auto mode: hold_cnt increments on each tick. When a tick arrives with hold_cnt==HOLD_FRAMES-1, set next_scene=scene+1 (mod 4), hold_cnt=0, go to WIPE.
  - Leaving auto mode clears hold_cnt.
  - If a manual request and the auto expiry land on the same tick, the manual request wins and hold_cnt clears.
- FSM state WIPE:
  - wiping=1.
  - At each tick, wipe_pos += WIPE_STEP, computed 11 bits wide so it cannot overflow.
  - If the new value is >= H_ACTIVE: scene<=next_scene, wipe_pos=0, hold_cnt=0, go to HOLD.
  - With the defaults, the transition takes exactly 20 ticks.
- Select change during WIPE:
  - Latched into a one-deep pending register; the latest value wins.
  - Acted on at the first tick in HOLD, and only if it still differs from scene.
- Boundaries:
  - Selecting the scene already displayed starts no transition.
  - auto_mode toggled mid-WIPE: the wipe completes normally.
  - pix_x >= H_ACTIVE: no effect, because video_active is low there.
  - reset mid-WIPE: returns to scene 0 immediately.

Optional Feature:
- Macro: SCENE_SEQ_WIPE_EN.
- Defined: the wipe is as described above.
- Undefined:
  - The WIPE state and wipe_pos are not built.
  - A transition becomes a hard cut: scene<=target on the triggering tick.
  - wiping is tied to 0.

Decomposition:
- Shared package scene_pkg holds:
  - scene id constants SCENE_GRASS=0, SCENE_UW=1, SCENE_BLUE=2, SCENE_GREEN=3
  - the solid colour constants for scenes 2 and 3
  - FSM state encodings
  - H_ACTIVE
- One natural sub-module, frame_tick_gen: vsync edge detect plus frame_count. It is reused by the sound block.

Test Plan:
- Reset: assert reset mid-frame, then release -> rgb=0, scene=0, frame_count=0, wiping=0; the first vsync rising edge gives frame_count=1.
- Manual cut: auto_mode=0, sel 0->2 -> wiping rises at the next tick. After 20 ticks, scene=2 and rgb=6'b000111 for a non-goose visible pixel.
- Mid-wipe pixels: after 5 ticks of a 0->3 wipe (wipe_pos=160):
  - pix_x=159 shows 6'b001101
  - pix_x=160 shows bg0_rgb
- Goose priority and blanking:
  - in_goose=1, goose_rgb=6'b111111 -> rgb=6'b111111 one cycle later.
  - video_active=0 -> rgb=0.
- Auto mode with HOLD_FRAMES=3 -> scene sequence 0,1,2,3,0; each wipe starts on the 3rd tick of its hold.
- Select changed twice during a wipe (to 1, then 3) -> after the wipe completes, the next transition targets 3 only.
